// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline: load-use stall,
// branch flush, registered EX forwarding selects and a halt/drain FSM.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic             IdReadRs,
  input  logic             IdReadRt,
  input  logic [REG_W-1:0] IdWriteReg,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             IdHalt,
  input  logic             ExTaken,
  input  logic             Go,
  output logic             PcWrite,
  output logic             IfIdWrite,
  output logic             IfIdFlush,
  output logic             IdExBubble,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Halted
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ex_wr_q, ex_load_q, mem_wr_q, wb_wr_q;
  logic [REG_W-1:0]   ex_dst_q, mem_dst_q, wb_dst_q;
  logic [1:0]         fwd_a_q, fwd_b_q;

  logic               ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, lu;
  logic [1:0]         fwd_a_c, fwd_b_c;

  // Operand matches against the shadow pipeline; $0 and non-writers never match.
  assign ex_hit_rs  = IdReadRs && ex_wr_q  && (ex_dst_q  != '0) && (ex_dst_q  == IdRs);
  assign ex_hit_rt  = IdReadRt && ex_wr_q  && (ex_dst_q  != '0) && (ex_dst_q  == IdRt);
  assign mem_hit_rs = IdReadRs && mem_wr_q && (mem_dst_q != '0) && (mem_dst_q == IdRs);
  assign mem_hit_rt = IdReadRt && mem_wr_q && (mem_dst_q != '0) && (mem_dst_q == IdRt);
  assign lu         = ex_load_q && (ex_hit_rs || ex_hit_rt);

  assign fwd_a_c = (ex_hit_rs && !ex_load_q) ? 2'd1 : (mem_hit_rs ? 2'd2 : 2'd0);
  assign fwd_b_c = (ex_hit_rt && !ex_load_q) ? 2'd1 : (mem_hit_rt ? 2'd2 : 2'd0);

  assign ForwardA = fwd_a_q;
  assign ForwardB = fwd_b_q;
  assign Halted   = (state_q == S_HALT);

  // Next-state and pipeline control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PcWrite    = 1'b1;
    IfIdWrite  = 1'b1;
    IfIdFlush  = 1'b0;
    IdExBubble = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (ExTaken) begin
          IfIdFlush  = 1'b1;
          IdExBubble = 1'b1;
        end else if (lu) begin
          PcWrite    = 1'b0;
          IfIdWrite  = 1'b0;
          IdExBubble = 1'b1;
        end else if (IdHalt) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        PcWrite    = 1'b0;
        IfIdWrite  = 1'b0;
        IdExBubble = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        PcWrite    = 1'b0;
        IfIdWrite  = 1'b0;
        IdExBubble = 1'b1;
        if (Go) begin
          IfIdFlush = 1'b1;
          state_d   = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State, drain counter, shadow destinations and registered forward selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      ex_wr_q   <= 1'b0;
      ex_dst_q  <= '0;
      ex_load_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_dst_q <= '0;
      wb_wr_q   <= 1'b0;
      wb_dst_q  <= '0;
      fwd_a_q   <= 2'd0;
      fwd_b_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_wr_q   <= IdExBubble ? 1'b0 : IdRegWrite;
      ex_dst_q  <= IdExBubble ? '0   : IdWriteReg;
      ex_load_q <= IdExBubble ? 1'b0 : IdMemRead;
      mem_wr_q  <= ex_wr_q;
      mem_dst_q <= ex_dst_q;
      wb_wr_q   <= mem_wr_q;
      wb_dst_q  <= mem_dst_q;
      fwd_a_q   <= IdExBubble ? 2'd0 : fwd_a_c;
      fwd_b_q   <= IdExBubble ? 2'd0 : fwd_b_c;
    end
  end

  // WB shadow is kept for completeness; the register file resolves WB hazards.
  logic wb_unused;
  assign wb_unused = wb_wr_q ^ (^wb_dst_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: an instruction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IdRs, IdRt, IdWriteReg;
  logic       IdReadRs, IdReadRt, IdRegWrite, IdMemRead, IdHalt, ExTaken, Go;
  logic       PcWrite, IfIdWrite, IfIdFlush, IdExBubble, Halted;
  logic [1:0] ForwardA, ForwardB;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(3), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .IdRs(IdRs), .IdRt(IdRt), .IdReadRs(IdReadRs), .IdReadRt(IdReadRt),
    .IdWriteReg(IdWriteReg), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdHalt(IdHalt), .ExTaken(ExTaken), .Go(Go),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
    .IdExBubble(IdExBubble), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .Halted(Halted)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the two in-flight instructions ahead of ID (index 0 = EX, 1 = MEM),
  // each reduced to the register it will write (0 = none) and a load flag.
  int   m_dst [2];
  bit   m_ld  [2];
  int   m_halt_age;   // -1 running, 0..2 draining, >=3 halted
  int   m_fa, m_fb;
  bit   m_valid = 1'b0;

  function automatic int src_of(input int r, input bit rd);
    if (!rd || r == 0)                return 0;
    if (m_dst[0] == r && !m_ld[0])    return 1;
    if (m_dst[1] == r)                return 2;
    return 0;
  endfunction

  function automatic bit load_use();
    return m_ld[0] && m_dst[0] != 0 &&
           ((IdReadRs && int'(IdRs) == m_dst[0]) || (IdReadRt && int'(IdRt) == m_dst[0]));
  endfunction

  // {PcWrite, IfIdWrite, IfIdFlush, IdExBubble}
  function automatic logic [3:0] ctl();
    if (m_halt_age < 0) begin
      if (ExTaken)    return 4'b1111;
      if (load_use()) return 4'b0001;
      return 4'b1100;
    end
    if (m_halt_age < 3) return 4'b0001;
    return {2'b00, Go, 1'b1};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_dst[0] = 0; m_dst[1] = 0; m_ld[0] = 0; m_ld[1] = 0;
      m_halt_age = -1; m_fa = 0; m_fb = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      logic [3:0] c;
      int nh;
      c  = ctl();
      nh = m_halt_age;
      if (m_halt_age < 0) begin
        if (!ExTaken && !load_use() && IdHalt) nh = 0;
      end else if (m_halt_age < 3) nh = m_halt_age + 1;
      else if (Go) nh = -1;
      m_fa = c[0] ? 0 : src_of(int'(IdRs), IdReadRs);
      m_fb = c[0] ? 0 : src_of(int'(IdRt), IdReadRt);
      m_dst[1] = m_dst[0];
      m_ld[1]  = m_ld[0];
      m_dst[0] = (c[0] || !IdRegWrite) ? 0 : int'(IdWriteReg);
      m_ld[0]  = c[0] ? 1'b0 : IdMemRead;
      m_halt_age = nh;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [3:0] c;
      c = ctl();
      check("PcWrite",    int'(PcWrite),    int'(c[3]));
      check("IfIdWrite",  int'(IfIdWrite),  int'(c[2]));
      check("IfIdFlush",  int'(IfIdFlush),  int'(c[1]));
      check("IdExBubble", int'(IdExBubble), int'(c[0]));
      check("ForwardA",   int'(ForwardA),   m_fa);
      check("ForwardB",   int'(ForwardB),   m_fb);
      check("Halted",     int'(Halted),     (m_halt_age >= 3) ? 1 : 0);
    end
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rrs,
                       input logic rrt, input logic [4:0] wd, input logic rw,
                       input logic mr, input logic hl, input logic ext, input logic g);
    @(posedge clk); #1;
    IdRs = rs; IdRt = rt; IdReadRs = rrs; IdReadRt = rrt; IdWriteReg = wd;
    IdRegWrite = rw; IdMemRead = mr; IdHalt = hl; ExTaken = ext; Go = g;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    drive(s, t, 1, 1, d, 1, 0, 0, 0, 0);
  endtask
  task automatic lw(input logic [4:0] d, input logic [4:0] s);
    drive(s, 5'd0, 1, 0, d, 1, 1, 0, 0, 0);
  endtask
  task automatic nop();
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask
  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    IdRs = '0; IdRt = '0; IdReadRs = 0; IdReadRt = 0; IdWriteReg = '0;
    IdRegWrite = 0; IdMemRead = 0; IdHalt = 0; ExTaken = 0; Go = 0;
    nop(); nop();
    settle();
    check("rst_PcWrite", int'(PcWrite), 1);
    check("rst_ForwardA", int'(ForwardA), 0);
    check("rst_Halted", int'(Halted), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Back-to-back ALU dependency
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd2);
    settle(); check("b2b_no_stall", int'(PcWrite), 1);
    nop();
    settle(); check("b2b_ForwardA", int'(ForwardA), 1);

    // Distance-2, then two writers of the same register
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd1, 5'd2);
    alu(5'd7, 5'd1, 5'd5);
    nop();
    settle(); check("dist2_ForwardB", int'(ForwardB), 2);
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd7, 5'd1, 5'd5);
    nop();
    settle(); check("younger_ForwardB", int'(ForwardB), 1);

    // Load-use stall of exactly one cycle
    lw(5'd8, 5'd1);
    alu(5'd9, 5'd8, 5'd2);
    settle();
    check("lu_PcWrite", int'(PcWrite), 0);
    check("lu_IfIdWrite", int'(IfIdWrite), 0);
    check("lu_Bubble", int'(IdExBubble), 1);
    alu(5'd9, 5'd8, 5'd2);
    settle();
    check("lu_release_PcWrite", int'(PcWrite), 1);
    check("lu_release_Bubble", int'(IdExBubble), 0);
    nop();
    settle(); check("lu_ForwardA", int'(ForwardA), 2);

    // $0 never matches
    lw(5'd0, 5'd1);
    alu(5'd11, 5'd0, 5'd0);
    settle(); check("r0_no_stall", int'(PcWrite), 1);
    nop();
    settle(); check("r0_ForwardA", int'(ForwardA), 0);

    // Branch flush beats load-use and halt in ID
    lw(5'd10, 5'd1);
    drive(5'd10, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1, 0);
    settle();
    check("br_Flush", int'(IfIdFlush), 1);
    check("br_Bubble", int'(IdExBubble), 1);
    check("br_PcWrite", int'(PcWrite), 1);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);   // Go ignored in RUN
    settle(); check("br_stay_run", int'(PcWrite), 1);

    // Halt, drain, hold, resume
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
    settle(); check("halt_issue_PcWrite", int'(PcWrite), 1);
    for (int i = 0; i < 3; i++) begin
      nop();
      settle();
      check("drain_PcWrite", int'(PcWrite), 0);
      check("drain_Halted", int'(Halted), 0);
    end
    nop(); settle(); check("halted", int'(Halted), 1);
    nop(); settle(); check("halted_hold", int'(Halted), 1);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    settle();
    check("go_Flush", int'(IfIdFlush), 1);
    check("go_PcWrite", int'(PcWrite), 0);
    nop();
    settle();
    check("resume_Halted", int'(Halted), 0);
    check("resume_PcWrite", int'(PcWrite), 1);

    // Reset in the middle of a drain
    alu(5'd12, 5'd1, 5'd2);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
    nop();
    nop(); rst = 1'b1;
    nop(); rst = 1'b0;
    settle();
    check("rst_drain_Halted", int'(Halted), 0);
    check("rst_drain_PcWrite", int'(PcWrite), 1);
    check("rst_drain_ForwardA", int'(ForwardA), 0);
    alu(5'd13, 5'd12, 5'd12);
    nop();
    settle(); check("rst_drain_fwd", int'(ForwardA), 0);
    nop(); nop();
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
